inst_fetch: RTL and testbench
=============================

Name: inst_fetch

Overview:
- Instruction-fetch requester that drives the synchronous instruction memory of the core.
- Generates the word-aligned fetch address and absorbs the memory's fixed 1-cycle read latency.
- Presents fetched instructions, each with its PC, to decode over a valid/ready handshake.
- Handles back-pressure with a 1-entry skid buffer, and handles redirects (branch/jump/trap) by flushing the in-flight read.

Parameters:
- RESET_PC, 32'h0000_0000: first fetch address after reset; bits[1:0] must be 0.

Ports:
- clk  input  1  core clock; the memory samples inst_addr on the same edge.
- rstn  input  1  asynchronous active-low reset.
- fetch_en_i  input  1  when 1, new fetch requests may issue; when 0, no new issue and in-flight reads still complete.
- redirect_i  input  1  flush and redirect request from later stages.
- redirect_pc_i  input  32  new PC; bits[1:0] are ignored and forced to 0.
- inst_addr  output  32  byte address to the instruction memory.
- inst_i  input  32  memory read data, valid one cycle after the address was issued.
- if_valid_o  output  1  instruction available to decode.
- if_ready_i  input  1  decode accepts the instruction; handshake completes on if_valid_o & if_ready_i.
- if_inst_o  output  32  instruction word.
- if_pc_o  output  32  PC of if_inst_o.

Behaviour:
- Reset (async assert, sync release) sets these registers:
  - pc_q = RESET_PC
  - rsp_vld_q = 0, rsp_pc_q = 0
  - skid_vld_q = 0, skid_inst_q = 0, skid_pc_q = 0
- Reset values at the outputs: inst_addr = RESET_PC, if_valid_o = 0, if_inst_o = inst_i (don't-care while invalid), if_pc_o = 0.
- Reset mid-operation discards everything; the first fetch after release is RESET_PC.
- inst_addr = pc_q, straight from the register with no combinational path.
- stall = skid_vld_q | (rsp_vld_q & ~if_ready_i).
- issue = fetch_en_i & ~stall & ~redirect_i.
- Clock edge with issue = 1: rsp_vld_q <= 1; rsp_pc_q <= pc_q; pc_q <= pc_q + 4. The add is 32-bit and wraps 0xFFFF_FFFC -> 0x0000_0000.
- Clock edge with issue = 0 and no redirect: rsp_vld_q <= 0; pc_q holds.
- Output mux:
  - if skid_vld_q: if_inst_o = skid_inst_q, if_pc_o = skid_pc_q.
  - else: if_inst_o = inst_i, if_pc_o = rsp_pc_q.
  - if_valid_o = (skid_vld_q | rsp_vld_q) & ~redirect_i.
- Skid capture: when rsp_vld_q & ~skid_vld_q & ~if_ready_i, latch inst_i and rsp_pc_q into the skid on the next edge (skid_vld_q <= 1).
- Skid drain: when skid_vld_q & if_ready_i, skid_vld_q <= 0.
- Invariant: skid_vld_q and rsp_vld_q are never both 1. The issue rule guarantees this; the bench asserts it.
- Latency and throughput:
  - Issue to if_valid_o is 1 cycle.
  - Sustained throughput is 1 instruction/cycle while if_ready_i = 1.
  - A single-cycle deassert of if_ready_i costs 1 extra bubble cycle after drain.
- Redirect has the highest priority. On redirect_i = 1:
  - if_valid_o = 0 in that cycle; any in-flight or skid instruction is dropped.
  - Next edge: pc_q <= {redirect_pc_i[31:2], 2'b00}, rsp_vld_q <= 0, skid_vld_q <= 0.
  - The memory read launched that cycle is discarded.
  - The first redirected instruction appears 2 cycles after redirect_i.
- Back-to-back redirects: the last one wins; each cancels the previous.
- fetch_en_i low with skid full: the skid is still presented and drains normally.
- Program order is preserved; no instruction is duplicated or dropped except on redirect.

Optional Feature:
- Macro: IFU_PERF_CNT_EN.
- Defined:
  - Adds output fetch_cnt_o[31:0]: increments on every handshake (if_valid_o & if_ready_i).
  - Adds output stall_cnt_o[31:0]: increments on every cycle with fetch_en_i & stall & ~redirect_i.
  - Both reset to 0, wrap at 2^32, and are not cleared by redirect.
- Undefined: neither port nor counter logic exists; behaviour is otherwise identical.

Test Plan:
- Reset release, RESET_PC = 0, if_ready_i = 1, memory preloaded with word n = 0x1000_0000 + n:
  - inst_addr = 0, 4, 8, ... on successive cycles.
  - if_valid_o first rises 1 cycle after release, with pc 0x0 / inst 0x1000_0000, then one per cycle.
- Back-pressure: while pc 0x8 is valid, hold if_ready_i = 0 for 3 cycles:
  - 0x8 / 0x1000_0002 is held stable, then accepted.
  - inst_addr stays 0xC during the stall; 0xC follows with no loss or duplication.
- Redirect to 0x0000_0042 while pc 0x10 is valid:
  - if_valid_o = 0 that cycle; next inst_addr = 0x40.
  - Next accepted pc is 0x40, 2 cycles later; 0x10 and 0x14 are never accepted.
- Redirect while the skid is full (if_ready_i = 0):
  - The skid entry is dropped; the next accepted pc is the redirect target.
- fetch_en_i = 0 after issuing pc 0x20:
  - The 0x20 instruction is still delivered, then if_valid_o = 0 and inst_addr holds 0x24.
  - Re-enabling resumes at 0x24.
- Wrap-around: redirect to 0xFFFF_FFFC:
  - inst_addr goes 0xFFFF_FFFC -> 0x0000_0000.
  - With IFU_PERF_CNT_EN, fetch_cnt_o matches the number of handshakes counted by the bench's scoreboard.

Source files
------------

// File: rtl/inst_fetch.sv
// inst_fetch: instruction-fetch requester for a synchronous instruction memory
// with a fixed 1-cycle read latency. It issues word-aligned fetch addresses and
// presents {instruction, PC} pairs to decode over a valid/ready handshake. A
// 1-entry skid buffer absorbs back-pressure, and redirects flush all in-flight
// state.
// Optional build macro: IFU_PERF_CNT_EN adds the fetch_cnt_o and stall_cnt_o
// performance counters.
module inst_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        fetch_en_i,
  input  logic        redirect_i,
  input  logic [31:0] redirect_pc_i,
  output logic [31:0] inst_addr,
  input  logic [31:0] inst_i,
  output logic        if_valid_o,
  input  logic        if_ready_i,
  output logic [31:0] if_inst_o,
  output logic [31:0] if_pc_o
`ifdef IFU_PERF_CNT_EN
  ,
  output logic [31:0] fetch_cnt_o,
  output logic [31:0] stall_cnt_o
`endif
);

  // Fetch address register and the response tracking for the read in flight.
  logic [31:0] pc_q, pc_d;
  logic        rsp_vld_q, rsp_vld_d;
  logic [31:0] rsp_pc_q, rsp_pc_d;

  // Skid entry holding an instruction that decode could not take in time.
  logic        skid_vld_q, skid_vld_d;
  logic [31:0] skid_inst_q, skid_inst_d;
  logic [31:0] skid_pc_q, skid_pc_d;

  logic        stall;
  logic        issue;
  logic        handshake;

  // The low two redirect address bits are dropped to keep fetches word-aligned.
  logic [1:0]  redirect_pc_unused;
  assign redirect_pc_unused = redirect_pc_i[1:0];

  // Memory address comes straight from the PC register.
  assign inst_addr = pc_q;

  // Flow control: stop issuing while the skid is occupied or a response is blocked.
  always_comb begin
    stall     = skid_vld_q | (rsp_vld_q & ~if_ready_i);
    issue     = fetch_en_i & ~stall & ~redirect_i;
    handshake = if_valid_o & if_ready_i;
  end

  // Output mux: the skid entry is older than the live memory response, so it goes first.
  always_comb begin
    if (skid_vld_q) begin
      if_inst_o = skid_inst_q;
      if_pc_o   = skid_pc_q;
    end else begin
      if_inst_o = inst_i;
      if_pc_o   = rsp_pc_q;
    end
    if_valid_o = (skid_vld_q | rsp_vld_q) & ~redirect_i;
  end

  // Next-state logic: a redirect overrides issue, skid capture and skid drain.
  always_comb begin
    pc_d        = pc_q;
    rsp_vld_d   = 1'b0;
    rsp_pc_d    = rsp_pc_q;
    skid_vld_d  = skid_vld_q;
    skid_inst_d = skid_inst_q;
    skid_pc_d   = skid_pc_q;

    if (redirect_i) begin
      pc_d       = {redirect_pc_i[31:2], 2'b00};
      rsp_vld_d  = 1'b0;
      skid_vld_d = 1'b0;
    end else begin
      if (issue) begin
        rsp_vld_d = 1'b1;
        rsp_pc_d  = pc_q;
        pc_d      = pc_q + 32'd4;
      end
      if (rsp_vld_q && !skid_vld_q && !if_ready_i) begin
        skid_vld_d  = 1'b1;
        skid_inst_d = inst_i;
        skid_pc_d   = rsp_pc_q;
      end else if (skid_vld_q && if_ready_i) begin
        skid_vld_d = 1'b0;
      end
    end
  end

  // State registers.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      pc_q        <= RESET_PC;
      rsp_vld_q   <= 1'b0;
      rsp_pc_q    <= 32'd0;
      skid_vld_q  <= 1'b0;
      skid_inst_q <= 32'd0;
      skid_pc_q   <= 32'd0;
    end else begin
      pc_q        <= pc_d;
      rsp_vld_q   <= rsp_vld_d;
      rsp_pc_q    <= rsp_pc_d;
      skid_vld_q  <= skid_vld_d;
      skid_inst_q <= skid_inst_d;
      skid_pc_q   <= skid_pc_d;
    end
  end

`ifdef IFU_PERF_CNT_EN
  // Free-running performance counters; only reset clears them, redirects do not.
  logic [31:0] fetch_cnt_q, fetch_cnt_d;
  logic [31:0] stall_cnt_q, stall_cnt_d;

  // Count handshakes and cycles where fetch wanted to issue but was blocked.
  always_comb begin
    fetch_cnt_d = fetch_cnt_q;
    stall_cnt_d = stall_cnt_q;
    if (handshake) begin
      fetch_cnt_d = fetch_cnt_q + 32'd1;
    end
    if (fetch_en_i && stall && !redirect_i) begin
      stall_cnt_d = stall_cnt_q + 32'd1;
    end
  end

  // Counter registers.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      fetch_cnt_q <= 32'd0;
      stall_cnt_q <= 32'd0;
    end else begin
      fetch_cnt_q <= fetch_cnt_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign fetch_cnt_o = fetch_cnt_q;
  assign stall_cnt_o = stall_cnt_q;
`else
  // Without the counters the handshake term has no consumer.
  logic perf_unused;
  assign perf_unused = handshake;
`endif

endmodule

// File: tb/tb_inst_fetch.sv
// Directed testbench for inst_fetch. A behavioural 1-cycle-latency memory
// returns word n = 0x1000_0000 + n. A negedge monitor logs every handshake,
// checks the instruction/PC pairing and the skid/response exclusivity, and
// the accepted PC stream is compared against a hand-written list.
module tb_inst_fetch;

  logic        clk = 1'b0;
  logic        rstn;
  logic        fetch_en_i;
  logic        redirect_i;
  logic [31:0] redirect_pc_i;
  logic [31:0] inst_addr;
  logic [31:0] inst_i;
  logic        if_valid_o;
  logic        if_ready_i;
  logic [31:0] if_inst_o;
  logic [31:0] if_pc_o;
`ifdef IFU_PERF_CNT_EN
  logic [31:0] fetch_cnt_o;
  logic [31:0] stall_cnt_o;
`endif

  int checks = 0;
  int errors = 0;
  int hs_cnt = 0;
  logic [31:0] acc_pc[$];

  always #5 clk = ~clk;

  inst_fetch #(.RESET_PC(32'h0000_0000)) dut (
    .clk           (clk),
    .rstn          (rstn),
    .fetch_en_i    (fetch_en_i),
    .redirect_i    (redirect_i),
    .redirect_pc_i (redirect_pc_i),
    .inst_addr     (inst_addr),
    .inst_i        (inst_i),
    .if_valid_o    (if_valid_o),
    .if_ready_i    (if_ready_i),
    .if_inst_o     (if_inst_o),
    .if_pc_o       (if_pc_o)
`ifdef IFU_PERF_CNT_EN
    ,
    .fetch_cnt_o   (fetch_cnt_o),
    .stall_cnt_o   (stall_cnt_o)
`endif
  );

  // Synchronous instruction memory: word n holds 0x1000_0000 + n.
  always @(posedge clk) inst_i <= 32'h1000_0000 + (inst_addr >> 2);

  // Handshake monitor and invariant check.
  always @(negedge clk) begin
    if (rstn) begin
      if (if_valid_o && if_ready_i) begin
        acc_pc.push_back(if_pc_o);
        hs_cnt++;
        $display("accept pc=%h inst=%h", if_pc_o, if_inst_o);
        checks++;
        if (if_inst_o !== 32'h1000_0000 + (if_pc_o >> 2)) begin
          errors++;
          $display("FAIL accept_inst: got %h expected %h", if_inst_o, 32'h1000_0000 + (if_pc_o >> 2));
        end
      end
      checks++;
      if (dut.skid_vld_q && dut.rsp_vld_q) begin
        errors++;
        $display("FAIL invariant: skid_vld_q and rsp_vld_q both set");
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rstn = 1'b0; fetch_en_i = 1'b0; redirect_i = 1'b0; redirect_pc_i = 32'd0; if_ready_i = 1'b1;
    repeat (3) @(posedge clk);
    #2;
    checks++; if (inst_addr !== 32'h0) begin errors++; $display("FAIL rst_addr: got %h expected 0", inst_addr); end
    checks++; if (if_valid_o !== 1'b0) begin errors++; $display("FAIL rst_valid: got %b expected 0", if_valid_o); end
    checks++; if (if_pc_o !== 32'h0) begin errors++; $display("FAIL rst_pc: got %h expected 0", if_pc_o); end
    checks++; if (if_inst_o !== 32'h1000_0000) begin errors++; $display("FAIL rst_inst: got %h expected 10000000", if_inst_o); end
`ifdef IFU_PERF_CNT_EN
    checks++; if (fetch_cnt_o !== 32'd0) begin errors++; $display("FAIL rst_fetch_cnt: got %0d expected 0", fetch_cnt_o); end
    checks++; if (stall_cnt_o !== 32'd0) begin errors++; $display("FAIL rst_stall_cnt: got %0d expected 0", stall_cnt_o); end
`endif
  endtask

  task automatic test_startup();
    rstn = 1'b1; fetch_en_i = 1'b1;
    #1;
    checks++; if (inst_addr !== 32'h0) begin errors++; $display("FAIL start_addr: got %h expected 0", inst_addr); end
    checks++; if (if_valid_o !== 1'b0) begin errors++; $display("FAIL start_valid: got %b expected 0", if_valid_o); end
    for (int k = 0; k < 3; k++) begin
      tick(); #1;
      checks++; if (inst_addr !== 32'(4 * (k + 1))) begin errors++; $display("FAIL seq_addr[%0d]: got %h expected %h", k, inst_addr, 4 * (k + 1)); end
      checks++; if (if_valid_o !== 1'b1) begin errors++; $display("FAIL seq_valid[%0d]: got %b expected 1", k, if_valid_o); end
      checks++; if (if_pc_o !== 32'(4 * k)) begin errors++; $display("FAIL seq_pc[%0d]: got %h expected %h", k, if_pc_o, 4 * k); end
      checks++; if (if_inst_o !== 32'(32'h1000_0000 + k)) begin errors++; $display("FAIL seq_inst[%0d]: got %h expected %h", k, if_inst_o, 32'h1000_0000 + k); end
    end
  endtask

  task automatic test_backpressure();
    if_ready_i = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (i == 3) if_ready_i = 1'b1;
      #1;
      checks++; if (if_valid_o !== 1'b1) begin errors++; $display("FAIL bp_valid[%0d]: got %b expected 1", i, if_valid_o); end
      checks++; if (if_pc_o !== 32'h8) begin errors++; $display("FAIL bp_pc[%0d]: got %h expected 8", i, if_pc_o); end
      checks++; if (if_inst_o !== 32'h1000_0002) begin errors++; $display("FAIL bp_inst[%0d]: got %h expected 10000002", i, if_inst_o); end
      checks++; if (inst_addr !== 32'hC) begin errors++; $display("FAIL bp_addr[%0d]: got %h expected c", i, inst_addr); end
      tick();
    end
    #1;
    checks++; if (if_valid_o !== 1'b0) begin errors++; $display("FAIL bp_bubble: got %b expected 0", if_valid_o); end
    checks++; if (inst_addr !== 32'hC) begin errors++; $display("FAIL bp_bubble_addr: got %h expected c", inst_addr); end
    tick(); #1;
    checks++; if (if_valid_o !== 1'b1 || if_pc_o !== 32'hC) begin errors++; $display("FAIL bp_resume: got valid=%b pc=%h expected valid=1 pc=c", if_valid_o, if_pc_o); end
    checks++; if (inst_addr !== 32'h10) begin errors++; $display("FAIL bp_resume_addr: got %h expected 10", inst_addr); end
  endtask

  task automatic test_redirect();
    tick(); #1;
    checks++; if (if_valid_o !== 1'b1 || if_pc_o !== 32'h10) begin errors++; $display("FAIL rd_pre: got valid=%b pc=%h expected valid=1 pc=10", if_valid_o, if_pc_o); end
    redirect_i = 1'b1; redirect_pc_i = 32'h0000_0042;
    #1;
    checks++; if (if_valid_o !== 1'b0) begin errors++; $display("FAIL rd_valid: got %b expected 0", if_valid_o); end
    tick(); redirect_i = 1'b0; #1;
    checks++; if (inst_addr !== 32'h40) begin errors++; $display("FAIL rd_addr: got %h expected 40", inst_addr); end
    checks++; if (if_valid_o !== 1'b0) begin errors++; $display("FAIL rd_gap: got %b expected 0", if_valid_o); end
    tick(); #1;
    checks++; if (if_valid_o !== 1'b1 || if_pc_o !== 32'h40) begin errors++; $display("FAIL rd_target: got valid=%b pc=%h expected valid=1 pc=40", if_valid_o, if_pc_o); end
    checks++; if (if_inst_o !== 32'h1000_0010) begin errors++; $display("FAIL rd_inst: got %h expected 10000010", if_inst_o); end
  endtask

  task automatic test_redirect_skid();
    if_ready_i = 1'b0;
    tick(); #1;
    checks++; if (if_valid_o !== 1'b1 || if_pc_o !== 32'h40) begin errors++; $display("FAIL rs_skid: got valid=%b pc=%h expected valid=1 pc=40", if_valid_o, if_pc_o); end
    redirect_i = 1'b1; redirect_pc_i = 32'h0000_0080;
    #1;
    checks++; if (if_valid_o !== 1'b0) begin errors++; $display("FAIL rs_valid: got %b expected 0", if_valid_o); end
    tick(); redirect_i = 1'b0; if_ready_i = 1'b1; #1;
    checks++; if (if_valid_o !== 1'b0) begin errors++; $display("FAIL rs_dropped: got %b expected 0", if_valid_o); end
    checks++; if (inst_addr !== 32'h80) begin errors++; $display("FAIL rs_addr: got %h expected 80", inst_addr); end
    tick(); #1;
    checks++; if (if_valid_o !== 1'b1 || if_pc_o !== 32'h80 || if_inst_o !== 32'h1000_0020) begin errors++; $display("FAIL rs_target: got valid=%b pc=%h inst=%h expected 1/80/10000020", if_valid_o, if_pc_o, if_inst_o); end
  endtask

  task automatic test_fetch_en();
    tick(); #1;
    checks++; if (if_pc_o !== 32'h84) begin errors++; $display("FAIL fe_pre: got %h expected 84", if_pc_o); end
    redirect_i = 1'b1; redirect_pc_i = 32'h0000_0020;
    tick(); redirect_i = 1'b0; #1;
    checks++; if (inst_addr !== 32'h20) begin errors++; $display("FAIL fe_addr20: got %h expected 20", inst_addr); end
    tick(); fetch_en_i = 1'b0; #1;
    checks++; if (if_valid_o !== 1'b1 || if_pc_o !== 32'h20 || if_inst_o !== 32'h1000_0008) begin errors++; $display("FAIL fe_deliver: got valid=%b pc=%h inst=%h expected 1/20/10000008", if_valid_o, if_pc_o, if_inst_o); end
    for (int i = 0; i < 2; i++) begin
      tick(); #1;
      checks++; if (if_valid_o !== 1'b0) begin errors++; $display("FAIL fe_idle_valid[%0d]: got %b expected 0", i, if_valid_o); end
      checks++; if (inst_addr !== 32'h24) begin errors++; $display("FAIL fe_idle_addr[%0d]: got %h expected 24", i, inst_addr); end
    end
    fetch_en_i = 1'b1;
    tick(); #1;
    checks++; if (if_valid_o !== 1'b1 || if_pc_o !== 32'h24 || inst_addr !== 32'h28) begin errors++; $display("FAIL fe_resume: got valid=%b pc=%h addr=%h expected 1/24/28", if_valid_o, if_pc_o, inst_addr); end
    tick(); if_ready_i = 1'b0; #1;
    checks++; if (if_pc_o !== 32'h28) begin errors++; $display("FAIL fe_pc28: got %h expected 28", if_pc_o); end
    tick(); fetch_en_i = 1'b0; #1;
    checks++; if (if_valid_o !== 1'b1 || if_pc_o !== 32'h28 || if_inst_o !== 32'h1000_000A) begin errors++; $display("FAIL fe_skid: got valid=%b pc=%h inst=%h expected 1/28/1000000a", if_valid_o, if_pc_o, if_inst_o); end
    tick(); if_ready_i = 1'b1; #1;
    checks++; if (if_valid_o !== 1'b1 || if_pc_o !== 32'h28) begin errors++; $display("FAIL fe_skid_hold: got valid=%b pc=%h expected 1/28", if_valid_o, if_pc_o); end
    tick(); #1;
    checks++; if (if_valid_o !== 1'b0 || inst_addr !== 32'h2C) begin errors++; $display("FAIL fe_drained: got valid=%b addr=%h expected 0/2c", if_valid_o, inst_addr); end
  endtask

  task automatic test_wrap();
    fetch_en_i = 1'b1; redirect_i = 1'b1; redirect_pc_i = 32'hFFFF_FFFE;
    tick(); redirect_i = 1'b0; #1;
    checks++; if (inst_addr !== 32'hFFFF_FFFC) begin errors++; $display("FAIL wr_addr: got %h expected fffffffc", inst_addr); end
    tick(); #1;
    checks++; if (if_valid_o !== 1'b1 || if_pc_o !== 32'hFFFF_FFFC || if_inst_o !== 32'h4FFF_FFFF) begin errors++; $display("FAIL wr_top: got valid=%b pc=%h inst=%h expected 1/fffffffc/4fffffff", if_valid_o, if_pc_o, if_inst_o); end
    checks++; if (inst_addr !== 32'h0) begin errors++; $display("FAIL wr_wrap_addr: got %h expected 0", inst_addr); end
    tick(); #1;
    checks++; if (if_pc_o !== 32'h0 || if_inst_o !== 32'h1000_0000 || inst_addr !== 32'h4) begin errors++; $display("FAIL wr_zero: got pc=%h inst=%h addr=%h expected 0/10000000/4", if_pc_o, if_inst_o, inst_addr); end
    tick(); #1;
`ifdef IFU_PERF_CNT_EN
    checks++; if (fetch_cnt_o !== 32'(hs_cnt)) begin errors++; $display("FAIL fetch_cnt: got %0d expected %0d", fetch_cnt_o, hs_cnt); end
`endif
  endtask

  task automatic test_sequence();
    logic [31:0] exp_pc [10];
    exp_pc = '{32'h0, 32'h4, 32'h8, 32'hC, 32'h80, 32'h20, 32'h24, 32'h28, 32'hFFFF_FFFC, 32'h0};
    checks++;
    if (acc_pc.size() != 10) begin
      errors++; $display("FAIL seq_count: got %0d expected 10", acc_pc.size());
    end else begin
      for (int i = 0; i < 10; i++) begin
        checks++;
        if (acc_pc[i] !== exp_pc[i]) begin errors++; $display("FAIL seq_pc_order[%0d]: got %h expected %h", i, acc_pc[i], exp_pc[i]); end
      end
    end
  endtask

  task automatic test_reset_mid();
    rstn = 1'b0;
    #1;
    checks++; if (inst_addr !== 32'h0 || if_valid_o !== 1'b0 || if_pc_o !== 32'h0) begin errors++; $display("FAIL mid_rst: got addr=%h valid=%b pc=%h expected 0/0/0", inst_addr, if_valid_o, if_pc_o); end
`ifdef IFU_PERF_CNT_EN
    checks++; if (fetch_cnt_o !== 32'd0) begin errors++; $display("FAIL mid_rst_cnt: got %0d expected 0", fetch_cnt_o); end
`endif
    tick(); tick();
    rstn = 1'b1;
    tick(); #1;
    checks++; if (if_valid_o !== 1'b1 || if_pc_o !== 32'h0 || inst_addr !== 32'h4) begin errors++; $display("FAIL mid_restart: got valid=%b pc=%h addr=%h expected 1/0/4", if_valid_o, if_pc_o, inst_addr); end
  endtask

  initial begin
    test_reset();
    test_startup();
    test_backpressure();
    test_redirect();
    test_redirect_skid();
    test_fetch_en();
    test_wrap();
    test_sequence();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
